// File: rtl/pipe_rca_adder_param.sv
// Segment-pipelined ripple-carry adder/subtractor with a valid/ready handshake.
// Defining PIPE_RCA_OVF_EN adds a registered signed-overflow output (ovf).
module pipe_rca_adder_param #(
  parameter int BW     = 32,
  parameter int STAGES = 4
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic          cin,
  input  logic          sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] sum,
  output logic          cout
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam int SW = BW / STAGES;

  // One segment ripple built from generate/propagate cells; returns {carry_out, sum}.
  function automatic logic [SW:0] seg_add(input logic [SW-1:0] a,
                                          input logic [SW-1:0] b,
                                          input logic          ci);
    logic [SW:0]   c;
    logic [SW-1:0] s;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    return {c[SW], s};
  endfunction

  logic          en_s;
  logic [BW-1:0] sum_q;
  logic          cout_q;
  logic          out_valid_q;

  // The whole pipeline moves together unless a finished result is waiting.
  assign en_s      = !out_valid_q || out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM = BW - k * SW;

    logic [REM-1:0]        a_s;
    logic [REM-1:0]        b_s;
    logic                  c_s;
    logic                  v_s;
    logic [SW:0]           seg_s;
    logic [(k+1)*SW-1:0]   res_s;

    assign seg_s = seg_add(a_s[SW-1:0], b_s[SW-1:0], c_s);

    if (k == 0) begin : g_src
      // Subtraction is folded in here so later stages only ever add.
      assign a_s   = A;
      assign b_s   = sub ? ~B : B;
      assign c_s   = sub ? 1'b1 : cin;
      assign v_s   = in_valid;
      assign res_s = seg_s[SW-1:0];
    end else begin : g_src
      assign a_s   = g_stg[k-1].g_reg.a_q;
      assign b_s   = g_stg[k-1].g_reg.b_q;
      assign c_s   = g_stg[k-1].g_reg.c_q;
      assign v_s   = g_stg[k-1].g_reg.v_q;
      assign res_s = {seg_s[SW-1:0], g_stg[k-1].g_reg.done_q};
    end

    if (k < STAGES - 1) begin : g_reg
      logic [REM-SW-1:0]   a_q;
      logic [REM-SW-1:0]   b_q;
      logic [(k+1)*SW-1:0] done_q;
      logic                c_q;
      logic                v_q;

      // Inter-stage register: remaining operand bits, finished low segments, carry.
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          a_q    <= '0;
          b_q    <= '0;
          done_q <= '0;
          c_q    <= 1'b0;
          v_q    <= 1'b0;
        end else if (en_s) begin
          a_q    <= a_s[REM-1:SW];
          b_q    <= b_s[REM-1:SW];
          done_q <= res_s;
          c_q    <= seg_s[SW];
          v_q    <= v_s;
        end
      end
    end else begin : g_out
      // Output register: full sum, carry out of the MSB and the result valid.
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          sum_q       <= '0;
          cout_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end else if (en_s) begin
          sum_q       <= res_s;
          cout_q      <= seg_s[SW];
          out_valid_q <= v_s;
        end
      end

`ifdef PIPE_RCA_OVF_EN
      logic ovf_q;
      // Carry into the MSB is recovered as a^b^s at that bit.
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          ovf_q <= 1'b0;
        end else if (en_s) begin
          ovf_q <= (a_s[SW-1] ^ b_s[SW-1] ^ seg_s[SW-1]) ^ seg_s[SW];
        end
      end
      assign ovf = ovf_q;
`endif
    end
  end

endmodule

// File: doc/pipe_rca_adder_param.md
Name: pipe_rca_adder_param

Overview:
- Parametrised, handshaked, segment-pipelined ripple-carry adder/subtractor. It generalises the team's fixed 32-bit, 2-stage pipelined RCA.
- Operand width BW is split into STAGES equal segments. Each pipeline stage ripples one segment using generate/propagate gray-cell carry logic, and the carry is registered between stages.
- The block sits between operand-producing logic and any consumer that needs valid/ready flow control and one result per cycle.

Parameters:
- BW, 32: operand and sum width in bits.
- STAGES, 4: number of register stages. BW must be divisible by STAGES. Legal range 1..BW.
- SW, BW/STAGES: segment width. Derived localparam, not overridable.

Ports:
- CLK  input  1  clock, rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept this cycle.
- A  input  BW  operand A.
- B  input  BW  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (computed as A+~B+1).
- out_valid  output  1  sum/cout hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  BW  result, registered.
- cout  output  1  carry out of bit BW-1 (for sub=1: 1 = no borrow).

Behaviour:
- Reset: when RESETn is asserted, all stage registers, per-stage valid bits, sum, cout and out_valid clear to 0 immediately. in_ready reads 1 while reset is held and after release.
- Reset during operation discards every in-flight transaction. No partial result is ever emitted.
- Global enable: en = !out_valid | out_ready. in_ready = en (combinational). Accept occurs when in_valid && in_ready at a rising edge.
- When en=0, every register, including the per-stage valid bits, holds its value. sum, cout and out_valid stay stable until out_ready.
- Stage structure:
  - The stage-0 combinational path adds segment 0 (bits SW-1:0) of A and B' with carry c0. B' = sub ? ~B : B; c0 = sub ? 1 : cin.
  - On accept, the stage-1 registers capture the segment-0 sum, the segment-0 carry-out, and the not-yet-added upper operand bits (A and B' already conditioned).
  - Stage k (1..STAGES-1) adds segment k of the carried operands with the registered carry. Completed low segments shift forward unchanged, keeping the result deskewed.
  - The final stage writes full sum and cout into the output registers.
- STAGES=1 degenerates to a registered single-cycle ripple adder with handshake.
- Latency: with no stall, a transaction accepted at edge 1 appears at sum/cout with out_valid=1 after edge STAGES. Each stalled cycle adds exactly one cycle.
- Throughput: one transaction per cycle while out_ready=1. Bubbles (in_valid=0) propagate as cleared valid bits. Bubble stages may still clock data, but out_valid=0 for them.
- Simultaneous events:
  - If the output is consumed and a new input is accepted in the same cycle, both occur.
  - If out_valid=0 and out_ready=0, the pipeline still advances, so bubbles never cause a stall.
- Arithmetic is modulo 2^BW. cout is the true carry out of the MSB of A+B'+c0. No saturation.
- sum is unsigned-agnostic. The block never reads X on operand bits of bubble stages into valid results.

Optional Feature:
- Macro PIPE_RCA_OVF_EN.
- Defined: adds output port ovf (output, 1 bit), the signed two's-complement overflow of the result, computed as carry into bit BW-1 XOR carry out of bit BW-1. ovf is registered alongside sum, resets to 0, and holds under stall.
- Undefined: no ovf port, and no extra registers or logic.

Test Plan:
- BW=32, STAGES=4: accept A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 at edge 1 with out_ready=1 → after edge 4, out_valid=1, sum=0x00000000, cout=1; out_valid=0 at edges 1-3.
- Three back-to-back accepts (1+2 cin=1, 0x80000000+0x80000000, 0x0000FFFF+0x00000001) → results 0x00000004 c0, 0x00000000 c1, 0x00010000 c0 on three consecutive cycles after edges 4, 5, 6.
- sub=1, 5-7 → sum=0xFFFFFFFE, cout=0. sub=1, 7-5 → sum=0x00000002, cout=1. cin toggled during both has no effect.
- Result valid with out_ready held 0 for 3 cycles → sum/cout/out_valid stable, in_ready=0, and a new operand with in_valid high is not accepted. On out_ready=1, the next result follows with no loss or duplication.
- Three transactions in flight, RESETn pulsed low mid-cycle → outputs clear immediately, and no stale out_valid appears in the 4 cycles after release.
- With PIPE_RCA_OVF_EN defined: 0x7FFFFFFF+1 → ovf=1; 0x80000000-1 (sub) → ovf=1; 0x00000003+0x00000004 → ovf=0. Repeat the latency test with STAGES=1 and STAGES=8 → results after edge 1 and edge 8 respectively.
